// File: rtl/cronometro_pkg.sv
// Shared stopwatch definitions: FSM state encodings and default timing
// constants used by the control and display stages.
package cronometro_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int DEF_CLK_HZ       = 50_000_000;
    localparam int DEF_TICK_HZ      = 1000;
    localparam int DEF_DEBOUNCE_CYC = 500_000;

    // Bits needed for a counter holding 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter and a
// one-cycle press pulse on the debounced released->pressed transition.
module btn_debounce
    import cronometro_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYC);

    logic             sync_1;
    logic             sync_2;
    logic             stable_n;
    logic             stable_n_d;
    logic [CNT_W-1:0] cnt;

    // NOTE: state is updated with <= so every flop samples the values from
    // before the edge; blocking here would collapse the synchronizer chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1     <= 1'b1;
            sync_2     <= 1'b1;
            stable_n   <= 1'b1;
            stable_n_d <= 1'b1;
            cnt        <= '0;
            press      <= 1'b0;
        end else begin
            sync_1     <= btn_n;
            sync_2     <= sync_1;
            stable_n_d <= stable_n;
            press      <= stable_n_d & ~stable_n;

            // A sample matching the accepted level means the input bounced back.
            if (sync_2 == stable_n) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                stable_n <= sync_2;
                cnt      <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cronometro_control.sv
// Stopwatch control: debounced start/stop and clear, IDLE/RUN/PAUSE FSM,
// tick prescaler and counter clear. Define CRONOMETRO_LAP_EN for lap_hold.
module cronometro_control
    import cronometro_pkg::*;
#(
    parameter int CLK_HZ       = DEF_CLK_HZ,
    parameter int TICK_HZ      = DEF_TICK_HZ,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start_stop_n,
    input  logic       btn_clear_n,
    output logic       enable,
    output logic       cnt_rst_n,
    output logic       running,
`ifdef CRONOMETRO_LAP_EN
    output logic       lap_hold,
`endif
    output logic [1:0] state
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = cnt_width(DIV);

    logic             ss_press;
    logic             clr_press;
    state_t           state_q;
    state_t           state_nxt;
    logic             clear_req;
    logic             rst_d;
    logic [PRE_W-1:0] presc;
    logic             wrap;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_ss (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_start_stop_n),
        .press (ss_press)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_clr (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_clear_n),
        .press (clr_press)
    );

    assign wrap  = (presc == PRE_W'(DIV - 1));
    assign state = state_q;

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt = state_q;
        clear_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr_press) begin
                    clear_req = 1'b1;
                end else if (ss_press) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ss_press) begin
                    state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (clr_press) begin
                    state_nxt = ST_IDLE;
                    clear_req = 1'b1;
                end else if (ss_press) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            running   <= 1'b0;
            enable    <= 1'b0;
            cnt_rst_n <= 1'b0;
            rst_d     <= 1'b1;
            presc     <= '0;
`ifdef CRONOMETRO_LAP_EN
            lap_hold  <= 1'b0;
`endif
        end else begin
            state_q   <= state_nxt;
            running   <= (state_nxt == ST_RUN);
            rst_d     <= 1'b0;
            // Held low one extra cycle after reset so the counter sees a clean clear.
            cnt_rst_n <= ~(rst_d | clear_req);
            enable    <= (state_q == ST_RUN) && wrap;

            if (state_q == ST_RUN) begin
                presc <= wrap ? '0 : presc + PRE_W'(1);
            end else if (state_q == ST_IDLE || clear_req) begin
                presc <= '0;
            end

`ifdef CRONOMETRO_LAP_EN
            if (state_q == ST_RUN && clr_press) begin
                lap_hold <= ~lap_hold;
            end else if (state_nxt == ST_IDLE) begin
                lap_hold <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_cronometro_control.sv
// Self-checking bench for cronometro_control with DIV=10, DEBOUNCE_CYC=4;
// enable pulses are checked against a queue of expected cycle numbers.
`timescale 1ns/1ps
module tb_cronometro_control;
    import cronometro_pkg::*;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int DEB     = 4;
    localparam int C0      = 10;
    localparam int N_STEPS = 14;

    typedef struct {
        bit     ss;
        bit     clr;
        state_t st;
        bit     clr_pulse;
        bit     lap;
    } step_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ss_n = 1'b1;
    logic       clr_n = 1'b1;
    logic       enable;
    logic       cnt_rst_n;
    logic       running;
    logic [1:0] state;
`ifdef CRONOMETRO_LAP_EN
    logic       lap_hold;
`endif

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int cnt_lows = 0;
    int exp_q[$];
    bit sb_on = 1'b0;
    bit bad_state = 1'b0;

    cronometro_control #(
        .CLK_HZ       (CLK_HZ),
        .TICK_HZ      (TICK_HZ),
        .DEBOUNCE_CYC (DEB)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .btn_start_stop_n (ss_n),
        .btn_clear_n      (clr_n),
        .enable           (enable),
        .cnt_rst_n        (cnt_rst_n),
        .running          (running),
`ifdef CRONOMETRO_LAP_EN
        .lap_hold         (lap_hold),
`endif
        .state            (state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic check_state(input string name, input state_t st);
        check(name, state, st);
        check({name, "_running"}, running, (st == ST_RUN));
    endtask

    task automatic check_lap(input string name, input bit lap);
`ifdef CRONOMETRO_LAP_EN
        check(name, lap_hold, lap);
`endif
    endtask

    // Monitor: scoreboard for enable pulses, clear-pulse tally, illegal state.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && state == 2'd3) bad_state = 1'b1;
            if (!rst && cyc >= 5 && cnt_rst_n !== 1'b1) cnt_lows++;
            if (sb_on && enable !== 1'b0) begin
                if (exp_q.size() == 0) check("enable_unexpected", cyc, 0);
                else check("enable_cycle", cyc, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish by cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        step_t tbl[N_STEPS];
        int d;

        tbl[0]  = '{ss: 1'b0, clr: 1'b1, st: ST_IDLE,  clr_pulse: 1'b1, lap: 1'b0};
        tbl[1]  = '{ss: 1'b1, clr: 1'b1, st: ST_IDLE,  clr_pulse: 1'b1, lap: 1'b0};
        tbl[2]  = '{ss: 1'b1, clr: 1'b0, st: ST_RUN,   clr_pulse: 1'b0, lap: 1'b0};
        tbl[3]  = '{ss: 1'b0, clr: 1'b1, st: ST_RUN,   clr_pulse: 1'b0, lap: 1'b1};
        tbl[4]  = '{ss: 1'b1, clr: 1'b0, st: ST_PAUSE, clr_pulse: 1'b0, lap: 1'b1};
        tbl[5]  = '{ss: 1'b0, clr: 1'b1, st: ST_IDLE,  clr_pulse: 1'b1, lap: 1'b0};
        tbl[6]  = '{ss: 1'b1, clr: 1'b0, st: ST_RUN,   clr_pulse: 1'b0, lap: 1'b0};
        tbl[7]  = '{ss: 1'b1, clr: 1'b0, st: ST_PAUSE, clr_pulse: 1'b0, lap: 1'b0};
        tbl[8]  = '{ss: 1'b1, clr: 1'b0, st: ST_RUN,   clr_pulse: 1'b0, lap: 1'b0};
        tbl[9]  = '{ss: 1'b1, clr: 1'b1, st: ST_PAUSE, clr_pulse: 1'b0, lap: 1'b1};
        tbl[10] = '{ss: 1'b1, clr: 1'b0, st: ST_RUN,   clr_pulse: 1'b0, lap: 1'b1};
        tbl[11] = '{ss: 1'b0, clr: 1'b1, st: ST_RUN,   clr_pulse: 1'b0, lap: 1'b0};
        tbl[12] = '{ss: 1'b1, clr: 1'b0, st: ST_PAUSE, clr_pulse: 1'b0, lap: 1'b0};
        tbl[13] = '{ss: 1'b0, clr: 1'b1, st: ST_IDLE,  clr_pulse: 1'b1, lap: 1'b0};

        // Reset held for three edges, then the one-cycle trailing clear.
        wait_until(1);
        check_state("rst_state", ST_IDLE);
        check("rst_enable", enable, 0);
        check("rst_cnt_rst_n", cnt_rst_n, 0);
        check_lap("rst_lap", 1'b0);
        wait_until(3);
        check("rst_cnt_rst_n_held", cnt_rst_n, 0);
        rst = 1'b0;
        wait_until(4);
        check("post_rst_cnt_rst_n_low", cnt_rst_n, 0);
        wait_until(5);
        check("post_rst_cnt_rst_n_high", cnt_rst_n, 1);

        // Expected enable cycles for the whole run/pause/resume sequence.
        wait_until(C0);
        for (int i = 0; i < 7; i++) exp_q.push_back(C0 + 18 + 10 * i);
        for (int i = 0; i < 8; i++) exp_q.push_back(C0 + 188 + 10 * i);
        exp_q.push_back(C0 + 288);
        sb_on = 1'b1;

        // Clean press held 20 cycles: one transition, first tick DIV later.
        ss_n = 1'b0;
        wait_until(C0 + 7);   check_state("ss_latency_idle", ST_IDLE);
        wait_until(C0 + 8);   check_state("ss_to_run", ST_RUN);
        wait_until(C0 + 20);  ss_n = 1'b1;
        wait_until(C0 + 40);  check_state("held_single_event", ST_RUN);

        // Pause with prescaler at 6, stay paused 100 cycles, resume.
        wait_until(C0 + 76);  ss_n = 1'b0;
        wait_until(C0 + 83);  check_state("pause_pre", ST_RUN);
        wait_until(C0 + 84);  ss_n = 1'b1; check_state("pause", ST_PAUSE);
        wait_until(C0 + 176); ss_n = 1'b0;
        wait_until(C0 + 184); ss_n = 1'b1; check_state("resume", ST_RUN);

        // clr while running: no state change or clear; lap toggles if built in.
        wait_until(C0 + 200); clr_n = 1'b0;
        wait_until(C0 + 207); check_lap("lap_before", 1'b0);
        wait_until(C0 + 208); clr_n = 1'b1; check_lap("lap_on", 1'b1); check_state("clr_in_run", ST_RUN);
        wait_until(C0 + 230); clr_n = 1'b0;
        wait_until(C0 + 237); check_lap("lap_still_on", 1'b1);
        wait_until(C0 + 238); clr_n = 1'b1; check_lap("lap_off", 1'b0);
        wait_until(C0 + 250); check_state("clr_in_run_2", ST_RUN); check("no_clear_in_run", cnt_lows, 0);

        // Pause on a wrap edge (pulse still emitted), resume, pause, clear.
        ss_n = 1'b0;
        wait_until(C0 + 258); ss_n = 1'b1; check_state("pause_on_wrap", ST_PAUSE);
        wait_until(C0 + 270); ss_n = 1'b0;
        wait_until(C0 + 278); ss_n = 1'b1; check_state("resume_2", ST_RUN);
        wait_until(C0 + 285); ss_n = 1'b0;
        wait_until(C0 + 293); ss_n = 1'b1; check_state("pause_2", ST_PAUSE);
        wait_until(C0 + 300); clr_n = 1'b0;
        wait_until(C0 + 307); check_state("clear_pre", ST_PAUSE); check("clear_pre_cnt", cnt_rst_n, 1);
        wait_until(C0 + 308); clr_n = 1'b1; check_state("clear_to_idle", ST_IDLE); check("clear_cnt_low", cnt_rst_n, 0);
        wait_until(C0 + 309); check("clear_cnt_high", cnt_rst_n, 1); check("clear_one_cycle", cnt_lows, 1);

        // Bouncing start: toggles every 2 cycles, then a stable low.
        for (int i = 0; i < 3; i++) exp_q.push_back(C0 + 360 + 10 * i);
        for (int i = 0; i < 6; i++) begin
            wait_until(C0 + 330 + 2 * i);
            ss_n = (i % 2 == 1);
        end
        wait_until(C0 + 342); ss_n = 1'b0; check_state("bounce_idle", ST_IDLE);
        wait_until(C0 + 349); check_state("bounce_latency", ST_IDLE);
        wait_until(C0 + 350); check_state("bounce_to_run", ST_RUN);
        wait_until(C0 + 362); ss_n = 1'b1;

        // Same-cycle ss+clr: in RUN ss wins, in PAUSE clr wins.
        wait_until(C0 + 375); ss_n = 1'b0; clr_n = 1'b0;
        wait_until(C0 + 382); check_state("both_run_pre", ST_RUN);
        wait_until(C0 + 383); ss_n = 1'b1; clr_n = 1'b1;
        check_state("both_in_run", ST_PAUSE); check_lap("both_in_run_lap", 1'b1);
        check("both_in_run_no_clear", cnt_lows, 1);
        wait_until(C0 + 400); ss_n = 1'b0; clr_n = 1'b0;
        wait_until(C0 + 408); ss_n = 1'b1; clr_n = 1'b1;
        check_state("both_in_pause", ST_IDLE); check("both_in_pause_cnt", cnt_rst_n, 0);
        check_lap("idle_clears_lap", 1'b0);
        wait_until(C0 + 409); check("both_in_pause_one_cycle", cnt_lows, 2);
        wait_until(C0 + 415); sb_on = 1'b0;
        check("enable_all_seen", exp_q.size(), 0);

        // Table walk through every transition.
        for (int i = 0; i < N_STEPS; i++) begin
            d = C0 + 420 + 16 * i;
            wait_until(d);
            ss_n  = !tbl[i].ss;
            clr_n = !tbl[i].clr;
            wait_until(d + 8);
            ss_n  = 1'b1;
            clr_n = 1'b1;
            check_state($sformatf("tbl%0d_state", i), tbl[i].st);
            check($sformatf("tbl%0d_cnt_rst_n", i), cnt_rst_n, !tbl[i].clr_pulse);
            check_lap($sformatf("tbl%0d_lap", i), tbl[i].lap);
            wait_until(d + 9);
            check($sformatf("tbl%0d_cnt_rst_n_after", i), cnt_rst_n, 1);
        end

        check("no_state_3", bad_state, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
